serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator.sv | 143 ++++++++++++++
 tb/tb_serial_comparator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: captures two operands, walks them one bit pair per cycle,
// and reports a registered one-hot gt/eq/lt verdict with a single-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; result flags hold the last verdict
// SHIFT | examining one bit pair per cycle
// DONE  | one-cycle result strobe, always returns to IDLE
module serial_comparator #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int SIGNED    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_gt_q, run_gt_d;
  logic             run_lt_q, run_lt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic bit_a, bit_b, is_msb, diff, pair_gt, pair_lt;
  logic new_gt, new_lt, finish;

  always_comb begin
    bit_a   = (MSB_FIRST != 0) ? a_sh_q[WIDTH-1] : a_sh_q[0];
    bit_b   = (MSB_FIRST != 0) ? b_sh_q[WIDTH-1] : b_sh_q[0];
    is_msb  = (MSB_FIRST != 0) ? (cnt_q == '0) : (cnt_q == LAST_IDX);
    diff    = bit_a ^ bit_b;
    // The sign bit of a two's-complement operand carries negative weight.
    pair_gt = ((SIGNED != 0) && is_msb) ? (~bit_a & bit_b) : (bit_a & ~bit_b);
    pair_lt = diff & ~pair_gt;
    new_gt  = diff ? pair_gt : run_gt_q;
    new_lt  = diff ? pair_lt : run_lt_q;
    finish  = (cnt_q == LAST_IDX) || ((MSB_FIRST != 0) && diff);

    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    cnt_d    = cnt_q;
    run_gt_d = run_gt_q;
    run_lt_d = run_lt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d  = SHIFT;
          a_sh_d   = a;
          b_sh_d   = b;
          cnt_d    = '0;
          run_gt_d = 1'b0;
          run_lt_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        a_sh_d   = (MSB_FIRST != 0) ? (a_sh_q << 1) : (a_sh_q >> 1);
        b_sh_d   = (MSB_FIRST != 0) ? (b_sh_q << 1) : (b_sh_q >> 1);
        cnt_d    = cnt_q + CW'(1);
        run_gt_d = new_gt;
        run_lt_d = new_lt;
        if (finish) begin
          state_d = DONE;
          done_d  = 1'b1;
          gt_d    = new_gt;
          lt_d    = new_lt;
          eq_d    = ~(new_gt | new_lt);
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      cnt_q    <= '0;
      run_gt_q <= 1'b0;
      run_lt_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
      run_gt_q <= run_gt_d;
      run_lt_q <= run_lt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: four configurations side by side sharing clock, reset
// and operands, each with its own start; expected verdicts and latencies are hand-computed.
module tb_serial_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start;
  logic [7:0] a, b;
  logic [3:0] busy, done, gt, eq, lt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: unsigned MSB-first, 1: unsigned LSB-first, 2: signed MSB-first, 3: signed LSB-first
  serial_comparator #(.WIDTH(8), .MSB_FIRST(1), .SIGNED(0)) u_umsb (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a), .b(b),
    .busy(busy[0]), .done(done[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]));
  serial_comparator #(.WIDTH(8), .MSB_FIRST(0), .SIGNED(0)) u_ulsb (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a), .b(b),
    .busy(busy[1]), .done(done[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]));
  serial_comparator #(.WIDTH(8), .MSB_FIRST(1), .SIGNED(1)) u_smsb (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a), .b(b),
    .busy(busy[2]), .done(done[2]), .gt(gt[2]), .eq(eq[2]), .lt(lt[2]));
  serial_comparator #(.WIDTH(8), .MSB_FIRST(0), .SIGNED(1)) u_slsb (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .a(a), .b(b),
    .busy(busy[3]), .done(done[3]), .gt(gt[3]), .eq(eq[3]), .lt(lt[3]));

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags(input int idx);
    return {gt[idx], eq[idx], lt[idx]};
  endfunction

  // One comparison on DUT idx; latency counted in cycles after the start-sampling edge.
  task automatic run_cmp(input string tag, input int idx, input logic [7:0] va,
                         input logic [7:0] vb, input int exp_lat, input logic [2:0] exp_flags);
    int   c;
    int   busy_cnt;
    logic seen;
    @(negedge clk);
    a = va;
    b = vb;
    start[idx] = 1'b1;
    @(posedge clk);
    c = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      start[idx] = 1'b0;
      if (busy[idx]) busy_cnt++;
      if (done[idx]) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, c, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_flags"}, 32'(flags(idx)), 32'(exp_flags));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done[idx]), 32'd0);
    check({tag, "_busy_after"}, 32'(busy[idx]), 32'd0);
    check({tag, "_flags_held"}, 32'(flags(idx)), 32'(exp_flags));
  endtask

  initial begin
    int done_at;
    int pulses;
    rst_n = 1'b0;
    start = '0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({gt, eq, lt}), 32'd0);
    rst_n = 1'b1;

    run_cmp("umsb_80_7f", 0, 8'h80, 8'h7F, 2, F_GT);
    run_cmp("umsb_5a_5a", 0, 8'h5A, 8'h5A, 9, F_EQ);
    run_cmp("umsb_12_13", 0, 8'h12, 8'h13, 9, F_LT);
    run_cmp("umsb_40_20", 0, 8'h40, 8'h20, 3, F_GT);

    run_cmp("ulsb_01_02", 1, 8'h01, 8'h02, 9, F_LT);
    run_cmp("ulsb_ff_00", 1, 8'hFF, 8'h00, 9, F_GT);
    run_cmp("ulsb_33_33", 1, 8'h33, 8'h33, 9, F_EQ);

    run_cmp("smsb_80_01", 2, 8'h80, 8'h01, 2, F_LT);
    run_cmp("smsb_7f_ff", 2, 8'h7F, 8'hFF, 2, F_GT);
    run_cmp("smsb_fe_ff", 2, 8'hFE, 8'hFF, 9, F_LT);

    run_cmp("slsb_80_01", 3, 8'h80, 8'h01, 9, F_LT);
    run_cmp("slsb_01_81", 3, 8'h01, 8'h81, 9, F_GT);

    // start held high and operands changed mid-compare
    @(negedge clk);
    a = 8'h5A;
    b = 8'h5A;
    start[0] = 1'b1;
    @(posedge clk);
    done_at = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done[0] && done_at == 0) done_at = c;
      if (c == 3) begin
        a = 8'hFF;
        b = 8'h00;
      end
    end
    check("hold_latency", done_at, 9);
    check("hold_flags", 32'(flags(0)), 32'(F_EQ));
    @(negedge clk);
    check("hold_idle_gap", 32'(busy[0]), 32'd0);
    @(negedge clk);
    check("hold_restart_busy", 32'(busy[0]), 32'd1);
    start[0] = 1'b0;
    @(negedge clk);
    check("hold_second_done", 32'(done[0]), 32'd1);
    check("hold_second_flags", 32'(flags(0)), 32'(F_GT));
    @(negedge clk);

    // reset pulse in cycle 4 of a full-length compare
    a = 8'h01;
    b = 8'h02;
    start[1] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start[1] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_flags", 32'({gt, eq, lt}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done != 4'b0) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    check("mid_rst_flags_quiet", 32'({gt, eq, lt}), 32'd0);
    run_cmp("ulsb_after_rst", 1, 8'hFF, 8'h00, 9, F_GT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
